alu_pipe: RTL and testbench

- Parametrised successor to the single-cycle combinational ALU.
- Executes one integer RS entry per cycle through a LAT-stage register pipeline and broadcasts results on the CDB through a valid/grant handshake.
- Sits between the ALU reservation station and the CDB arbiter.
- Adds backpressure, bubble collapsing, rollback flush and an occupancy count.

---
 rtl/alu_pipe.sv | 190 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined integer ALU between the ALU reservation station and the CDB arbiter.
// LAT register stages, valid/grant backpressure with bubble collapsing, rollback flush, occupancy count.
module alu_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned OPT_W = 6,
    parameter int unsigned LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPT_W-1:0] in_opt,
    input  logic [XLEN-1:0]  in_val1,
    input  logic [XLEN-1:0]  in_val2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [ROB_W-1:0] in_rob_idx,
    output logic             cdb_valid,
    input  logic             cdb_grant,
    output logic [ROB_W-1:0] cdb_src,
    output logic [XLEN-1:0]  cdb_val,
    output logic             cdb_tk,
    output logic [2:0]       occupancy
);
    localparam int unsigned SH_W  = $clog2(XLEN);
    localparam int unsigned LAST  = LAT - 1;
    localparam int unsigned OCC_W = 3;

    localparam logic [OPT_W-1:0] OPT_LUI   = OPT_W'(1);
    localparam logic [OPT_W-1:0] OPT_AUIPC = OPT_W'(2);
    localparam logic [OPT_W-1:0] OPT_JAL   = OPT_W'(3);
    localparam logic [OPT_W-1:0] OPT_JALR  = OPT_W'(4);
    localparam logic [OPT_W-1:0] OPT_BEQ   = OPT_W'(5);
    localparam logic [OPT_W-1:0] OPT_BNE   = OPT_W'(6);
    localparam logic [OPT_W-1:0] OPT_BLT   = OPT_W'(7);
    localparam logic [OPT_W-1:0] OPT_BGE   = OPT_W'(8);
    localparam logic [OPT_W-1:0] OPT_BLTU  = OPT_W'(9);
    localparam logic [OPT_W-1:0] OPT_BGEU  = OPT_W'(10);
    localparam logic [OPT_W-1:0] OPT_ADDI  = OPT_W'(11);
    localparam logic [OPT_W-1:0] OPT_SLTI  = OPT_W'(12);
    localparam logic [OPT_W-1:0] OPT_SLTIU = OPT_W'(13);
    localparam logic [OPT_W-1:0] OPT_XORI  = OPT_W'(14);
    localparam logic [OPT_W-1:0] OPT_ORI   = OPT_W'(15);
    localparam logic [OPT_W-1:0] OPT_ANDI  = OPT_W'(16);
    localparam logic [OPT_W-1:0] OPT_SLLI  = OPT_W'(17);
    localparam logic [OPT_W-1:0] OPT_SRLI  = OPT_W'(18);
    localparam logic [OPT_W-1:0] OPT_SRAI  = OPT_W'(19);
    localparam logic [OPT_W-1:0] OPT_ADD   = OPT_W'(20);
    localparam logic [OPT_W-1:0] OPT_SUB   = OPT_W'(21);
    localparam logic [OPT_W-1:0] OPT_SLL   = OPT_W'(22);
    localparam logic [OPT_W-1:0] OPT_SLT   = OPT_W'(23);
    localparam logic [OPT_W-1:0] OPT_SLTU  = OPT_W'(24);
    localparam logic [OPT_W-1:0] OPT_XOR   = OPT_W'(25);
    localparam logic [OPT_W-1:0] OPT_SRL   = OPT_W'(26);
    localparam logic [OPT_W-1:0] OPT_SRA   = OPT_W'(27);
    localparam logic [OPT_W-1:0] OPT_OR    = OPT_W'(28);
    localparam logic [OPT_W-1:0] OPT_AND   = OPT_W'(29);

    logic [SH_W-1:0]  sh_r;
    logic [SH_W-1:0]  sh_i;
    logic [XLEN-1:0]  alu_val;
    logic             alu_tk;

    logic             v_q   [LAT];
    logic [ROB_W-1:0] rob_q [LAT];
    logic [XLEN-1:0]  val_q [LAT];
    logic             tk_q  [LAT];
    logic             v_n   [LAT];
    logic [ROB_W-1:0] rob_n [LAT];
    logic [XLEN-1:0]  val_n [LAT];
    logic             tk_n  [LAT];
    logic             adv   [LAT];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_n;

    // Stage S0 datapath: result and branch outcome from the issued operands
    always_comb begin
        sh_r    = in_val2[SH_W-1:0];
        sh_i    = in_imm[SH_W-1:0];
        alu_val = '0;
        alu_tk  = 1'b0;
        case (in_opt)
            OPT_ADD, OPT_JAL:                       alu_val = in_val1 + in_val2;
            OPT_ADDI, OPT_AUIPC, OPT_LUI, OPT_JALR: alu_val = in_val1 + in_imm;
            OPT_SUB:   alu_val = in_val1 - in_val2;
            OPT_AND:   alu_val = in_val1 & in_val2;
            OPT_ANDI:  alu_val = in_val1 & in_imm;
            OPT_OR:    alu_val = in_val1 | in_val2;
            OPT_ORI:   alu_val = in_val1 | in_imm;
            OPT_XOR:   alu_val = in_val1 ^ in_val2;
            OPT_XORI:  alu_val = in_val1 ^ in_imm;
            OPT_SLL:   alu_val = in_val1 << sh_r;
            OPT_SLLI:  alu_val = in_val1 << sh_i;
            OPT_SRL:   alu_val = in_val1 >> sh_r;
            OPT_SRLI:  alu_val = in_val1 >> sh_i;
            OPT_SRA:   alu_val = XLEN'($signed(in_val1) >>> sh_r);
            OPT_SRAI:  alu_val = XLEN'($signed(in_val1) >>> sh_i);
            OPT_SLT:   alu_val = XLEN'($signed(in_val1) < $signed(in_val2));
            OPT_SLTI:  alu_val = XLEN'($signed(in_val1) < $signed(in_imm));
            OPT_SLTU:  alu_val = XLEN'(in_val1 < in_val2);
            OPT_SLTIU: alu_val = XLEN'(in_val1 < in_imm);
            OPT_BEQ:   alu_tk  = (in_val1 == in_val2);
            OPT_BNE:   alu_tk  = (in_val1 != in_val2);
            OPT_BLT:   alu_tk  = ($signed(in_val1) < $signed(in_val2));
            OPT_BGE:   alu_tk  = ($signed(in_val1) >= $signed(in_val2));
            OPT_BLTU:  alu_tk  = (in_val1 < in_val2);
            OPT_BGEU:  alu_tk  = (in_val1 >= in_val2);
            default: begin
                alu_val = '0;
                alu_tk  = 1'b0;
            end
        endcase
    end

    // Advance chain: a stage moves when it is empty or everything downstream moves
    always_comb begin
        for (int i = 0; i < int'(LAT); i++) begin
            adv[i] = 1'b0;
        end
        adv[LAST] = !v_q[LAST] || cdb_grant;
        for (int i = int'(LAT) - 2; i >= 0; i--) begin
            adv[i] = !v_q[i] || adv[i+1];
        end
        in_ready = rdy && adv[0];
    end

    // Next stage contents; rollback drops everything including the same-cycle issue
    always_comb begin
        for (int i = 0; i < int'(LAT); i++) begin
            v_n[i]   = v_q[i];
            rob_n[i] = rob_q[i];
            val_n[i] = val_q[i];
            tk_n[i]  = tk_q[i];
        end
        occ_n = '0;
        if (rollback) begin
            for (int i = 0; i < int'(LAT); i++) begin
                v_n[i] = 1'b0;
            end
        end else begin
            for (int i = int'(LAT) - 1; i >= 1; i--) begin
                if (adv[i]) begin
                    v_n[i]   = v_q[i-1];
                    rob_n[i] = rob_q[i-1];
                    val_n[i] = val_q[i-1];
                    tk_n[i]  = tk_q[i-1];
                end
            end
            if (adv[0]) begin
                v_n[0]   = in_valid;
                rob_n[0] = in_rob_idx;
                val_n[0] = alu_val;
                tk_n[0]  = alu_tk;
            end
        end
        for (int i = 0; i < int'(LAT); i++) begin
            occ_n = occ_n + OCC_W'(v_n[i]);
        end
    end

    // Stage registers; rdy low freezes the whole pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LAT); i++) begin
                v_q[i]   <= 1'b0;
                rob_q[i] <= '0;
                val_q[i] <= '0;
                tk_q[i]  <= 1'b0;
            end
            occ_q <= '0;
        end else if (rdy) begin
            for (int i = 0; i < int'(LAT); i++) begin
                v_q[i]   <= v_n[i];
                rob_q[i] <= rob_n[i];
                val_q[i] <= val_n[i];
                tk_q[i]  <= tk_n[i];
            end
            occ_q <= occ_n;
        end
    end

    assign cdb_valid = v_q[LAST];
    assign cdb_src   = rob_q[LAST];
    assign cdb_val   = val_q[LAST];
    assign cdb_tk    = tk_q[LAST];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (LAT=2): latency, ALU ops, branches,
// backpressure, rollback, rdy freeze and reset.
module tb_alu_pipe;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ROB_W = 4;
    localparam int unsigned OPT_W = 6;
    localparam int unsigned LAT   = 2;

    localparam logic [5:0] OPT_LUI   = 6'd1;
    localparam logic [5:0] OPT_AUIPC = 6'd2;
    localparam logic [5:0] OPT_JAL   = 6'd3;
    localparam logic [5:0] OPT_JALR  = 6'd4;
    localparam logic [5:0] OPT_BEQ   = 6'd5;
    localparam logic [5:0] OPT_BNE   = 6'd6;
    localparam logic [5:0] OPT_BLT   = 6'd7;
    localparam logic [5:0] OPT_BGE   = 6'd8;
    localparam logic [5:0] OPT_BLTU  = 6'd9;
    localparam logic [5:0] OPT_BGEU  = 6'd10;
    localparam logic [5:0] OPT_ADDI  = 6'd11;
    localparam logic [5:0] OPT_SLTI  = 6'd12;
    localparam logic [5:0] OPT_SLTIU = 6'd13;
    localparam logic [5:0] OPT_XORI  = 6'd14;
    localparam logic [5:0] OPT_ORI   = 6'd15;
    localparam logic [5:0] OPT_ANDI  = 6'd16;
    localparam logic [5:0] OPT_SLLI  = 6'd17;
    localparam logic [5:0] OPT_SRLI  = 6'd18;
    localparam logic [5:0] OPT_SRAI  = 6'd19;
    localparam logic [5:0] OPT_ADD   = 6'd20;
    localparam logic [5:0] OPT_SUB   = 6'd21;
    localparam logic [5:0] OPT_SLL   = 6'd22;
    localparam logic [5:0] OPT_SLT   = 6'd23;
    localparam logic [5:0] OPT_SLTU  = 6'd24;
    localparam logic [5:0] OPT_XOR   = 6'd25;
    localparam logic [5:0] OPT_SRL   = 6'd26;
    localparam logic [5:0] OPT_SRA   = 6'd27;
    localparam logic [5:0] OPT_OR    = 6'd28;
    localparam logic [5:0] OPT_AND   = 6'd29;
    localparam logic [5:0] OPT_BAD   = 6'd63;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, in_valid, in_ready, cdb_grant;
    logic [5:0]  in_opt;
    logic [31:0] in_val1, in_val2, in_imm;
    logic [3:0]  in_rob_idx;
    logic        cdb_valid, cdb_tk;
    logic [3:0]  cdb_src;
    logic [31:0] cdb_val;
    logic [2:0]  occupancy;
    logic [37:0] cdb_obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign cdb_obs = {cdb_valid, cdb_src, cdb_val, cdb_tk};

    alu_pipe #(.XLEN(XLEN), .ROB_W(ROB_W), .OPT_W(OPT_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_ready(in_ready), .in_opt(in_opt),
        .in_val1(in_val1), .in_val2(in_val2), .in_imm(in_imm), .in_rob_idx(in_rob_idx),
        .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_src(cdb_src),
        .cdb_val(cdb_val), .cdb_tk(cdb_tk), .occupancy(occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] opt, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [3:0] rob);
        in_valid   = 1'b1;
        in_opt     = opt;
        in_val1    = a;
        in_val2    = b;
        in_imm     = imm;
        in_rob_idx = rob;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; cdb_grant = 1'b0;
        idle(); drive(OPT_ADD, 32'd1, 32'd1, 32'd0, 4'd1); idle();
        step(); step();
        n_checks++;
        if (cdb_obs !== 38'd0) begin n_fail++; $display("FAIL reset_cdb: got %h expected %h", cdb_obs, 38'd0); end
        n_checks++;
        if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single();
        cdb_grant = 1'b1;
        drive(OPT_ADD, 32'd5, 32'd7, 32'd0, 4'd3);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %b expected 1", in_ready); end
        step();
        idle();
        n_checks++;
        if (cdb_valid !== 1'b0 || occupancy !== 3'd1) begin
            n_fail++; $display("FAIL single_lat: got valid=%b occ=%0d expected valid=0 occ=1", cdb_valid, occupancy);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready1: got %b expected 1", in_ready); end
        step();
        n_checks++;
        if (cdb_obs !== {1'b1, 4'd3, 32'd12, 1'b0} || occupancy !== 3'd1) begin
            n_fail++; $display("FAIL single_beat: got %h occ=%0d expected %h occ=1", cdb_obs, occupancy, {1'b1, 4'd3, 32'd12, 1'b0});
        end
        step();
        n_checks++;
        if (cdb_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL single_drain: got valid=%b occ=%0d expected 0 0", cdb_valid, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  op [3];
        logic [31:0] a  [3];
        logic [31:0] b  [3];
        logic [31:0] ev [3];
        int j;
        op = '{OPT_SUB, OPT_SRA, OPT_SLTU};
        a  = '{32'd1, 32'h8000_0000, 32'd1};
        b  = '{32'd2, 32'd4, 32'hFFFF_FFFF};
        ev = '{32'hFFFF_FFFF, 32'hF800_0000, 32'd1};
        cdb_grant = 1'b1;
        for (int k = 0; k < 3 + int'(LAT) - 1; k++) begin
            if (k < 3) drive(op[k], a[k], b[k], 32'd0, 4'(k + 1)); else idle();
            step();
            if (k >= int'(LAT) - 1) begin
                j = k - int'(LAT) + 1;
                n_checks++;
                if (cdb_obs !== {1'b1, 4'(j + 1), ev[j], 1'b0}) begin
                    n_fail++; $display("FAIL b2b_%0d: got %h expected %h", j, cdb_obs, {1'b1, 4'(j + 1), ev[j], 1'b0});
                end
            end
        end
        step();
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got valid=%b expected 0", cdb_valid); end
    endtask

    task automatic test_alu_ops();
        logic [5:0]  op  [23];
        logic [31:0] a   [23];
        logic [31:0] b   [23];
        logic [31:0] imm [23];
        logic [31:0] ev  [23];
        int j;
        op  = '{OPT_AND, OPT_ORI, OPT_XOR, OPT_SLL, OPT_SRL, OPT_SRAI, OPT_SLT, OPT_SLTI,
                OPT_SLTIU, OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR, OPT_ADDI, OPT_SLL, OPT_SRLI,
                OPT_XORI, OPT_ANDI, OPT_OR, OPT_SLLI, OPT_SRA, OPT_BAD, OPT_ADD};
        a   = '{32'hF0F0, 32'h0F, 32'hFF, 32'd1, 32'h8000_0000, 32'hF000_0000, 32'hFFFF_FFFF, 32'd5,
                32'd5, 32'd0, 32'h1000, 32'h100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h100,
                32'hFF, 32'hFFFF, 32'hF0, 32'd3, 32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF};
        b   = '{32'hFF00, 32'd0, 32'h0F, 32'd31, 32'd31, 32'd0, 32'd1, 32'd0,
                32'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd33, 32'd0,
                32'd0, 32'd0, 32'h0F, 32'd0, 32'd4, 32'd5, 32'hFFFF_FFFF};
        imm = '{32'd0, 32'hF0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'hFFFF_FFFD,
                32'hFFFF_FFFD, 32'h1234_5000, 32'h2000, 32'd0, 32'd8, 32'd1, 32'd0, 32'h24,
                32'hFFFF_FFFF, 32'hFF, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0};
        ev  = '{32'hF000, 32'hFF, 32'hF0, 32'h8000_0000, 32'd1, 32'hFF00_0000, 32'd1, 32'd0,
                32'd1, 32'h1234_5000, 32'h3000, 32'h104, 32'h208, 32'd0, 32'd2, 32'h10,
                32'hFFFF_FF00, 32'hFF, 32'hFF, 32'h30, 32'h07FF_FFFF, 32'd0, 32'hFFFF_FFFE};
        cdb_grant = 1'b1;
        for (int k = 0; k < 23 + int'(LAT) - 1; k++) begin
            if (k < 23) drive(op[k], a[k], b[k], imm[k], 4'(k)); else idle();
            step();
            if (k >= int'(LAT) - 1) begin
                j = k - int'(LAT) + 1;
                n_checks++;
                if (cdb_obs !== {1'b1, 4'(j), ev[j], 1'b0}) begin
                    n_fail++; $display("FAIL alu_op_%0d: got %h expected %h", j, cdb_obs, {1'b1, 4'(j), ev[j], 1'b0});
                end
            end
        end
        step();
    endtask

    task automatic test_branch();
        logic [5:0]  op  [8];
        logic [31:0] a   [8];
        logic [31:0] b   [8];
        logic        etk [8];
        int j;
        op  = '{OPT_BLT, OPT_BGEU, OPT_BEQ, OPT_BNE, OPT_BGE, OPT_BLTU, OPT_BEQ, OPT_BGE};
        a   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd0};
        b   = '{32'd0, 32'd0, 32'd5, 32'd5, 32'd0, 32'd0, 32'd7, 32'd0};
        etk = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        cdb_grant = 1'b1;
        for (int k = 0; k < 8 + int'(LAT) - 1; k++) begin
            if (k < 8) drive(op[k], a[k], b[k], 32'h40, 4'(k + 8)); else idle();
            step();
            if (k >= int'(LAT) - 1) begin
                j = k - int'(LAT) + 1;
                n_checks++;
                if (cdb_obs !== {1'b1, 4'(j + 8), 32'd0, etk[j]}) begin
                    n_fail++; $display("FAIL branch_%0d: got %h expected %h", j, cdb_obs, {1'b1, 4'(j + 8), 32'd0, etk[j]});
                end
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        cdb_grant = 1'b0;
        drive(OPT_ADD, 32'd100, 32'd1, 32'd0, 4'd1);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_empty: got %b expected 1", in_ready); end
        step();
        drive(OPT_ADD, 32'd100, 32'd2, 32'd0, 4'd2);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_collapse: got %b expected 1", in_ready); end
        step();
        drive(OPT_ADD, 32'd100, 32'd3, 32'd0, 4'd3);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (cdb_obs !== {1'b1, 4'd1, 32'd101, 1'b0} || occupancy !== 3'd2) begin
                n_fail++; $display("FAIL bp_hold_%0d: got %h occ=%0d expected %h occ=2", k, cdb_obs, occupancy, {1'b1, 4'd1, 32'd101, 1'b0});
            end
            if (k < 2) step();
        end
        cdb_grant = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_grant: got %b expected 1", in_ready); end
        step();
        cdb_grant = 1'b0;
        idle();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cdb_obs !== {1'b1, 4'd2, 32'd102, 1'b0} || occupancy !== 3'd2) begin
                n_fail++; $display("FAIL bp_one_retire_%0d: got %h occ=%0d expected %h occ=2", k, cdb_obs, occupancy, {1'b1, 4'd2, 32'd102, 1'b0});
            end
            if (k < 1) step();
        end
        cdb_grant = 1'b1;
        step();
        n_checks++;
        if (cdb_obs !== {1'b1, 4'd3, 32'd103, 1'b0} || occupancy !== 3'd1) begin
            n_fail++; $display("FAIL bp_third: got %h occ=%0d expected %h occ=1", cdb_obs, occupancy, {1'b1, 4'd3, 32'd103, 1'b0});
        end
        step();
        n_checks++;
        if (cdb_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL bp_drain: got valid=%b occ=%0d expected 0 0", cdb_valid, occupancy);
        end
    endtask

    task automatic test_rollback();
        cdb_grant = 1'b0;
        drive(OPT_ADD, 32'd1, 32'd1, 32'd0, 4'd5);
        step();
        drive(OPT_ADD, 32'd2, 32'd2, 32'd0, 4'd6);
        step();
        n_checks++;
        if (occupancy !== 3'd2) begin n_fail++; $display("FAIL rb_full: got occ=%0d expected 2", occupancy); end
        drive(OPT_ADD, 32'd50, 32'd50, 32'd0, 4'd7);
        rollback  = 1'b1;
        cdb_grant = 1'b1;
        step();
        rollback = 1'b0;
        idle();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cdb_valid !== 1'b0 || occupancy !== 3'd0) begin
                n_fail++; $display("FAIL rb_flushed_%0d: got valid=%b occ=%0d expected 0 0", k, cdb_valid, occupancy);
            end
            step();
        end
        drive(OPT_ADD, 32'd3, 32'd4, 32'd0, 4'd9);
        step();
        idle();
        step();
        n_checks++;
        if (cdb_obs !== {1'b1, 4'd9, 32'd7, 1'b0}) begin
            n_fail++; $display("FAIL rb_recover: got %h expected %h", cdb_obs, {1'b1, 4'd9, 32'd7, 1'b0});
        end
        step();
    endtask

    task automatic test_rdy_freeze();
        cdb_grant = 1'b1;
        drive(OPT_ADD, 32'd1, 32'd1, 32'd0, 4'd1);
        step();
        drive(OPT_ADD, 32'd2, 32'd2, 32'd0, 4'd2);
        step();
        drive(OPT_ADD, 32'd3, 32'd3, 32'd0, 4'd3);
        rdy = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL frz_ready: got %b expected 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (cdb_obs !== {1'b1, 4'd1, 32'd2, 1'b0} || occupancy !== 3'd2) begin
                n_fail++; $display("FAIL frz_hold_%0d: got %h occ=%0d expected %h occ=2", k, cdb_obs, occupancy, {1'b1, 4'd1, 32'd2, 1'b0});
            end
        end
        rdy = 1'b1;
        step();
        n_checks++;
        if (cdb_obs !== {1'b1, 4'd2, 32'd4, 1'b0}) begin
            n_fail++; $display("FAIL frz_resume2: got %h expected %h", cdb_obs, {1'b1, 4'd2, 32'd4, 1'b0});
        end
        drive(OPT_ADD, 32'd4, 32'd4, 32'd0, 4'd4);
        step();
        idle();
        n_checks++;
        if (cdb_obs !== {1'b1, 4'd3, 32'd6, 1'b0}) begin
            n_fail++; $display("FAIL frz_resume3: got %h expected %h", cdb_obs, {1'b1, 4'd3, 32'd6, 1'b0});
        end
        step();
        n_checks++;
        if (cdb_obs !== {1'b1, 4'd4, 32'd8, 1'b0}) begin
            n_fail++; $display("FAIL frz_resume4: got %h expected %h", cdb_obs, {1'b1, 4'd4, 32'd8, 1'b0});
        end
        step();
        n_checks++;
        if (cdb_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL frz_drain: got valid=%b occ=%0d expected 0 0", cdb_valid, occupancy);
        end
    endtask

    task automatic test_reset_midstream();
        cdb_grant = 1'b0;
        drive(OPT_ADD, 32'h50, 32'h5, 32'd0, 4'd11);
        step();
        drive(OPT_BNE, 32'd1, 32'd2, 32'd0, 4'd10);
        step();
        n_checks++;
        if (cdb_obs !== {1'b1, 4'd11, 32'h55, 1'b0} || occupancy !== 3'd2) begin
            n_fail++; $display("FAIL rst_pre: got %h occ=%0d expected %h occ=2", cdb_obs, occupancy, {1'b1, 4'd11, 32'h55, 1'b0});
        end
        drive(OPT_ADD, 32'd9, 32'd9, 32'd0, 4'd12);
        rst = 1'b1;
        rdy = 1'b0;
        step();
        n_checks++;
        if (cdb_obs !== 38'd0 || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL rst_mid: got %h occ=%0d expected 0 occ=0", cdb_obs, occupancy);
        end
        rst = 1'b0;
        rdy = 1'b1;
        cdb_grant = 1'b1;
        idle();
        step();
        n_checks++;
        if (cdb_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_fail++; $display("FAIL rst_after: got valid=%b occ=%0d expected 0 0", cdb_valid, occupancy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
        in_opt = '0; in_val1 = '0; in_val2 = '0; in_imm = '0; in_rob_idx = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_alu_ops();
        test_branch();
        test_backpressure();
        test_rollback();
        test_rdy_freeze();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
